// File: rtl/pong_pkg.sv
// Shared constants and types for the AR pong ball path.
package pong_pkg;
  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int BALL_R      = 8;
  localparam int L_FACE      = 24;
  localparam int R_FACE      = 615;
  localparam int PADDLE_HALF = 32;
  localparam int SPEED_INIT  = 2;
  localparam int SPEED_MAX   = 8;
  localparam int SPEED_Y     = 2;

  localparam int POS_W = 13;
  localparam int SW    = 14;
  localparam int VEL_W = 5;

  typedef logic [POS_W-1:0]        pos_t;
  typedef logic signed [SW-1:0]    spos_t;
  typedef logic signed [VEL_W-1:0] vel_t;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    PLAY,
    SCORED
  } state_t;

  localparam pos_t ROW_C   = pos_t'(V_ACTIVE / 2);
  localparam pos_t COL_C   = pos_t'(H_ACTIVE / 2);
  localparam vel_t VX_INIT = vel_t'(SPEED_INIT);
  localparam vel_t VY_INIT = vel_t'(SPEED_Y);
  localparam vel_t VX_MAX  = vel_t'(SPEED_MAX);

  localparam spos_t TOP   = spos_t'(BALL_R);
  localparam spos_t BOT   = spos_t'(V_ACTIVE - 1 - BALL_R);
  localparam spos_t LHIT  = spos_t'(L_FACE + BALL_R);
  localparam spos_t RHIT  = spos_t'(R_FACE - BALL_R);
  localparam spos_t LMISS = spos_t'(BALL_R);
  localparam spos_t RMISS = spos_t'(H_ACTIVE - 1 - BALL_R);
  localparam spos_t REACH = spos_t'(PADDLE_HALF + BALL_R);

  function automatic spos_t sx_pos(input pos_t p);
    return $signed({1'b0, p});
  endfunction

  function automatic spos_t sx_vel(input vel_t v);
    return {{(SW-VEL_W){v[VEL_W-1]}}, v};
  endfunction
endpackage

// File: rtl/ball_collide.sv
// One physics step: wall bounce, paddle bounce, miss detection.
module ball_collide
  import pong_pkg::*;
(
  input  pos_t row,
  input  pos_t col,
  input  vel_t vx,
  input  vel_t vy,
  input  pos_t paddle_l_row,
  input  pos_t paddle_r_row,
  output pos_t nxt_row,
  output pos_t nxt_col,
  output vel_t nxt_vx,
  output vel_t nxt_vy,
  output logic miss_l,
  output logic miss_r
);
  spos_t r, c, nr, nc, dl, dr;
  vel_t mag, boost;
  logic near_l, near_r, hit_l, hit_r;

  always_comb begin
    r  = sx_pos(row);
    c  = sx_pos(col);
    nr = r + sx_vel(vy);
    nc = c + sx_vel(vx);
    dl = r - sx_pos(paddle_l_row);
    dr = r - sx_pos(paddle_r_row);
    near_l = (dl <= REACH) && (dl >= -REACH);
    near_r = (dr <= REACH) && (dr >= -REACH);
    mag   = vx[VEL_W-1] ? -vx : vx;
    boost = (mag >= VX_MAX) ? VX_MAX : mag + vel_t'(1);
    // paddle tests use the pre-step row
    hit_l = (vx < vel_t'(0)) && (c >= LHIT)
          && (nc < LHIT) && near_l;
    hit_r = (vx > vel_t'(0)) && (c <= RHIT)
          && (nc > RHIT) && near_r;
    miss_l = !hit_l && (nc < LMISS);
    miss_r = !hit_r && (nc > RMISS);

    nxt_row = nr[POS_W-1:0];
    nxt_vy  = vy;
    if (nr < TOP) begin
      nxt_row = TOP[POS_W-1:0];
      nxt_vy  = -vy;
    end else if (nr > BOT) begin
      nxt_row = BOT[POS_W-1:0];
      nxt_vy  = -vy;
    end

    nxt_col = nc[POS_W-1:0];
    nxt_vx  = vx;
    if (hit_l) begin
      nxt_col = LHIT[POS_W-1:0];
      nxt_vx  = boost;
    end else if (hit_r) begin
      nxt_col = RHIT[POS_W-1:0];
      nxt_vx  = -boost;
    end
  end
endmodule

// File: rtl/ball_motion.sv
// Per-frame ball state machine and position/velocity registers.
module ball_motion
  import pong_pkg::*;
#(
  parameter int SERVE_FRAMES = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             enable,
  input  logic [POS_W-1:0] paddle_l_row,
  input  logic [POS_W-1:0] paddle_r_row,
  output logic [POS_W-1:0] ball_row,
  output logic [POS_W-1:0] ball_col,
  output logic             ball_visible,
  output logic             score_l,
  output logic             score_r
);
  localparam int CW = $clog2(SERVE_FRAMES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_FRAMES - 1);

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  pos_t row_q, row_d, col_q, col_d;
  vel_t vx_q, vx_d, vy_q, vy_d;
  logic dir_q, dir_d;
  logic vis_q, vis_d, sl_q, sl_d, sr_q, sr_d;
  logic go_serve, last;

  pos_t nxt_row, nxt_col;
  vel_t nxt_vx, nxt_vy;
  logic miss_l, miss_r;

  ball_collide u_collide (
    .row          (row_q),
    .col          (col_q),
    .vx           (vx_q),
    .vy           (vy_q),
    .paddle_l_row (paddle_l_row),
    .paddle_r_row (paddle_r_row),
    .nxt_row      (nxt_row),
    .nxt_col      (nxt_col),
    .nxt_vx       (nxt_vx),
    .nxt_vy       (nxt_vy),
    .miss_l       (miss_l),
    .miss_r       (miss_r)
  );

  assign last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    col_d    = col_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    dir_d    = dir_q;
    vis_d    = vis_q;
    sl_d     = 1'b0;
    sr_d     = 1'b0;
    go_serve = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      row_d   = ROW_C;
      col_d   = COL_C;
      vx_d    = VX_INIT;
      vy_d    = VY_INIT;
      vis_d   = 1'b0;
    end else if (frame_tick) begin
      unique case (state_q)
        IDLE: go_serve = 1'b1;
        SERVE: begin
          if (last) begin
            state_d = PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PLAY: begin
          // the conceding side serves next
          if (miss_l || miss_r) begin
            state_d = SCORED;
            cnt_d   = '0;
            vis_d   = 1'b0;
            sr_d    = miss_l;
            sl_d    = miss_r;
            dir_d   = miss_l;
          end else begin
            row_d = nxt_row;
            col_d = nxt_col;
            vx_d  = nxt_vx;
            vy_d  = nxt_vy;
          end
        end
        SCORED: begin
          if (last) go_serve = 1'b1;
          else cnt_d = cnt_q + CW'(1);
        end
        default: state_d = IDLE;
      endcase
      if (go_serve) begin
        state_d = SERVE;
        cnt_d   = '0;
        row_d   = ROW_C;
        col_d   = COL_C;
        vis_d   = 1'b1;
        vx_d    = dir_q ? VX_INIT : -VX_INIT;
        vy_d    = VY_INIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= ROW_C;
      col_q   <= COL_C;
      vx_q    <= VX_INIT;
      vy_q    <= VY_INIT;
      dir_q   <= 1'b1;
      vis_q   <= 1'b0;
      sl_q    <= 1'b0;
      sr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      dir_q   <= dir_d;
      vis_q   <= vis_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
    end
  end

  assign ball_row     = row_q;
  assign ball_col     = col_q;
  assign ball_visible = vis_q;
  assign score_l      = sl_q;
  assign score_r      = sr_q;
endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: fixed vectors, corner sequences, random vs model.
module tb_ball_motion;
  localparam int SF = 4;
  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_SCORED = 3;

  logic clk = 1'b0;
  logic reset, frame_tick, enable;
  logic [12:0] paddle_l_row, paddle_r_row, ball_row, ball_col;
  logic ball_visible, score_l, score_r;
  int checks = 0;
  int errors = 0;

  int m_st, m_cnt, m_row, m_col, m_vx, m_vy, m_vis, m_sl, m_sr;
  bit m_dir_right;

  typedef struct {
    int ticks; int pr; int row; int col; int vis; int sl;
  } vec_t;
  vec_t tbl[12];

  ball_motion #(.SERVE_FRAMES(SF)) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .enable       (enable),
    .paddle_l_row (paddle_l_row),
    .paddle_r_row (paddle_r_row),
    .ball_row     (ball_row),
    .ball_col     (ball_col),
    .ball_visible (ball_visible),
    .score_l      (score_l),
    .score_r      (score_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string n, input int r, input int c,
                         input int v, input int sl, input int sr);
    chk($sformatf("%s_row", n), 32'(ball_row), r);
    chk($sformatf("%s_col", n), 32'(ball_col), c);
    chk($sformatf("%s_vis", n), 32'(ball_visible), v);
    chk($sformatf("%s_score_l", n), 32'(score_l), sl);
    chk($sformatf("%s_score_r", n), 32'(score_r), sr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    frame_tick = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic tick_once();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int clampi(input int x);
    return (x < 0) ? 0 : (x > 479) ? 479 : x;
  endfunction

  task automatic m_serve();
    m_st = M_SERVE; m_cnt = 0; m_row = 240; m_col = 320;
    m_vis = 1; m_vx = m_dir_right ? 2 : -2; m_vy = 2;
  endtask

  task automatic m_idle();
    m_st = M_IDLE; m_cnt = 0; m_row = 240; m_col = 320;
    m_vis = 0; m_vx = 2; m_vy = 2;
  endtask

  // One frame of game rules, written from the game description.
  task automatic m_play(input int pl, input int pr);
    int nr, nc, nrow, nvy, sp;
    bit hl, hr;
    nr = m_row + m_vy;
    nc = m_col + m_vx;
    nrow = nr; nvy = m_vy;
    if (nr < 8) begin nrow = 8; nvy = -m_vy; end
    else if (nr > 471) begin nrow = 471; nvy = -m_vy; end
    sp = iabs(m_vx) + 1;
    if (sp > 8) sp = 8;
    hl = m_vx < 0 && m_col >= 32 && nc < 32 && iabs(m_row - pl) <= 40;
    hr = m_vx > 0 && m_col <= 607 && nc > 607 && iabs(m_row - pr) <= 40;
    if (hl) begin
      m_row = nrow; m_vy = nvy; m_col = 32; m_vx = sp;
    end else if (hr) begin
      m_row = nrow; m_vy = nvy; m_col = 607; m_vx = -sp;
    end else if (nc < 8) begin
      m_sr = 1; m_dir_right = 1; m_st = M_SCORED; m_vis = 0; m_cnt = 0;
    end else if (nc > 631) begin
      m_sl = 1; m_dir_right = 0; m_st = M_SCORED; m_vis = 0; m_cnt = 0;
    end else begin
      m_row = nrow; m_vy = nvy; m_col = nc;
    end
  endtask

  task automatic model_clk(input bit rst, input bit en, input bit tk,
                           input int pl, input int pr);
    if (rst) begin
      m_idle(); m_dir_right = 1; m_sl = 0; m_sr = 0;
    end else begin
      m_sl = 0; m_sr = 0;
      if (!en) m_idle();
      else if (tk) begin
        case (m_st)
          M_IDLE: m_serve();
          M_SERVE: begin
            m_cnt++;
            if (m_cnt == SF) begin m_st = M_PLAY; m_cnt = 0; end
          end
          M_PLAY: m_play(pl, pr);
          default: begin
            m_cnt++;
            if (m_cnt == SF) m_serve();
          end
        endcase
      end
    end
  endtask

  initial begin
    int off;
    reset = 1'b1; frame_tick = 1'b0; enable = 1'b1;
    paddle_l_row = 13'd240; paddle_r_row = 13'd100;
    m_dir_right = 1;

    tbl[0]  = '{1,   100, 240, 320, 1, 0};
    tbl[1]  = '{5,   100, 240, 320, 1, 0};
    tbl[2]  = '{6,   100, 242, 322, 1, 0};
    tbl[3]  = '{121, 100, 471, 552, 1, 0};
    tbl[4]  = '{122, 100, 469, 554, 1, 0};
    tbl[5]  = '{149, 415, 415, 607, 1, 0};
    tbl[6]  = '{150, 415, 413, 604, 1, 0};
    tbl[7]  = '{160, 100, 393, 630, 1, 0};
    tbl[8]  = '{161, 100, 393, 630, 0, 1};
    tbl[9]  = '{165, 100, 240, 320, 1, 0};
    tbl[10] = '{169, 100, 240, 320, 1, 0};
    tbl[11] = '{170, 100, 242, 318, 1, 0};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_out("reset", 240, 320, 0, 0, 0);

    foreach (tbl[i]) begin
      do_reset();
      paddle_r_row = 13'(tbl[i].pr);
      repeat (tbl[i].ticks) tick_once();
      chk_out($sformatf("vec%0d", i), tbl[i].row, tbl[i].col,
              tbl[i].vis, tbl[i].sl, 0);
    end

    // miss on back-to-back ticks: pulse still one clock
    do_reset();
    paddle_r_row = 13'd100;
    repeat (160) tick_once();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    chk_out("b2b_miss", 393, 630, 0, 1, 0);
    @(negedge clk);
    frame_tick = 1'b0;
    chk_out("b2b_next", 393, 630, 0, 0, 0);
    // serve side survives an enable drop
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    chk_out("en_drop_idle", 240, 320, 0, 0, 0);
    repeat (6) tick_once();
    chk_out("serve_left", 242, 318, 1, 0, 0);

    // enable drop mid-play
    do_reset();
    repeat (15) tick_once();
    chk_out("mid_play", 260, 340, 1, 0, 0);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk_out("en_off", 240, 320, 0, 0, 0);
    enable = 1'b1;

    // enable dropped on the miss tick: no pulse
    do_reset();
    repeat (160) tick_once();
    @(negedge clk);
    frame_tick = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    frame_tick = 1'b0;
    enable = 1'b1;
    chk_out("en_off_miss", 240, 320, 0, 0, 0);

    // reset between ticks mid-play
    do_reset();
    repeat (15) tick_once();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_out("mid_reset", 240, 320, 0, 0, 0);

    // tick coincident with reset is ignored
    @(negedge clk);
    reset = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    frame_tick = 1'b0;
    chk_out("reset_tick", 240, 320, 0, 0, 0);
    tick_once();
    chk_out("after_reset_tick", 240, 320, 1, 0, 0);

    // random frames against the model
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      reset = (i == 0) || ($urandom_range(0, 4999) == 0);
      enable = (i < 5) || ($urandom_range(0, 2999) != 0);
      frame_tick = ($urandom_range(0, 1) == 1);
      off = int'($urandom_range(0, 100)) - 50;
      if ($urandom_range(0, 3) != 0)
        paddle_l_row = 13'(clampi(m_row + off));
      else
        paddle_l_row = 13'($urandom_range(0, 479));
      off = int'($urandom_range(0, 100)) - 50;
      if ($urandom_range(0, 3) != 0)
        paddle_r_row = 13'(clampi(m_row + off));
      else
        paddle_r_row = 13'($urandom_range(0, 479));
      model_clk(reset, enable, frame_tick,
                int'(paddle_l_row), int'(paddle_r_row));
      @(posedge clk);
      #1;
      chk_out("rnd", m_row, m_col, m_vis, m_sl, m_sr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
